// File: rtl/id_remap_if.sv
// Alloc/free/response bundle between a requester and id_remap_table.
// master drives the requests; slave is the remap table.
interface id_remap_if #(
    parameter int ID_WIDTH = 4,
    parameter int UID_W    = 4
);
    logic                alloc_valid;
    logic [ID_WIDTH-1:0] alloc_orig_id;
    logic                alloc_ready;
    logic [UID_W-1:0]    alloc_uid;
    logic                free_valid;
    logic [UID_W-1:0]    free_uid;
    logic                rsp_valid;
    logic [ID_WIDTH-1:0] rsp_orig_id;
    logic                rsp_err;

    modport master (
        output alloc_valid, alloc_orig_id, free_valid, free_uid,
        input  alloc_ready, alloc_uid, rsp_valid, rsp_orig_id, rsp_err
    );

    modport slave (
        input  alloc_valid, alloc_orig_id, free_valid, free_uid,
        output alloc_ready, alloc_uid, rsp_valid, rsp_orig_id, rsp_err
    );
endinterface

// File: rtl/id_remap_table.sv
// Remaps original IDs onto {row,col} unique IDs; alloc ready/uid are combinational, free responds one cycle later.
// Optional free checking (rsp_err on non-valid slot) is enabled by the macro ID_REMAP_ERR_CHECK_EN.
module id_remap_table #(
    parameter int ID_WIDTH = 4,
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4,
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int UID_W = ROW_W + COL_W,
    localparam int TOTAL = NUM_ROWS * NUM_COLS,
    localparam int CNT_W = $clog2(TOTAL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    id_remap_if.slave        bus,
    output logic [CNT_W-1:0] outstanding,
    output logic             full,
    output logic             empty
);

    logic [NUM_ROWS-1:0][NUM_COLS-1:0] valid_q, valid_d;
    logic [NUM_ROWS-1:0][ID_WIDTH-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]                  cnt_q;

    logic                hit_found, unbound_found, col_found, alloc_fire;
    logic [ROW_W-1:0]    hit_row, unbound_row, sel_row, free_row;
    logic [COL_W-1:0]    sel_col, free_col;
    logic                free_hit, free_eff;
    logic [ID_WIDTH-1:0] free_tag, rsp_id_d, rsp_id_q;
    logic                rsp_valid_q;

    // Row choice: a bound row with a matching tag wins, otherwise the lowest unbound row.
    always_comb begin
        hit_found     = 1'b0;
        hit_row       = '0;
        unbound_found = 1'b0;
        unbound_row   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (|valid_q[r]) begin
                if (!hit_found && tag_q[r] == bus.alloc_orig_id) begin
                    hit_found = 1'b1;
                    hit_row   = ROW_W'(r);
                end
            end else if (!unbound_found) begin
                unbound_found = 1'b1;
                unbound_row   = ROW_W'(r);
            end
        end
        sel_row   = hit_found ? hit_row : unbound_row;
        col_found = 1'b0;
        sel_col   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (ROW_W'(r) == sel_row && !valid_q[r][c] && !col_found) begin
                    col_found = 1'b1;
                    sel_col   = COL_W'(c);
                end
            end
        end
    end

    // A full hit row stalls rather than spilling, so one original ID never spans two rows.
    assign bus.alloc_ready = !rst && (hit_found ? col_found : unbound_found);
    assign bus.alloc_uid   = {sel_row, sel_col};
    assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;

    assign free_row = bus.free_uid[UID_W-1:COL_W];
    assign free_col = bus.free_uid[COL_W-1:0];

    // Out-of-range row/col never matches a loop index, so it reads as a non-valid slot.
    always_comb begin
        free_tag = '0;
        free_hit = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (ROW_W'(r) == free_row) begin
                free_tag = tag_q[r];
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (COL_W'(c) == free_col) begin
                        free_hit = valid_q[r][c];
                    end
                end
            end
        end
    end

    assign free_eff = bus.free_valid && free_hit;

    // Alloc only targets non-valid slots and free only clears valid ones, so they never collide.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (free_eff && ROW_W'(r) == free_row && COL_W'(c) == free_col) begin
                    valid_d[r][c] = 1'b0;
                end
                if (alloc_fire && ROW_W'(r) == sel_row && COL_W'(c) == sel_col) begin
                    valid_d[r][c] = 1'b1;
                end
            end
            if (alloc_fire && !hit_found && ROW_W'(r) == sel_row) begin
                tag_d[r] = bus.alloc_orig_id;
            end
        end
    end

`ifdef ID_REMAP_ERR_CHECK_EN
    logic rsp_err_q;

    assign rsp_id_d = (bus.free_valid && free_hit) ? free_tag : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= bus.free_valid && !free_hit;
        end
    end

    assign bus.rsp_err = rsp_err_q && !rst;
`else
    assign rsp_id_d    = bus.free_valid ? free_tag : '0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_q + CNT_W'(alloc_fire) - CNT_W'(free_eff);
            rsp_valid_q <= bus.free_valid;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Outputs are forced to their idle values for the whole time rst is high.
    assign bus.rsp_valid   = rsp_valid_q && !rst;
    assign bus.rsp_orig_id = rst ? '0 : rsp_id_q;
    assign outstanding     = rst ? '0 : cnt_q;
    assign full            = !rst && (cnt_q == CNT_W'(TOTAL));
    assign empty           = rst || (cnt_q == '0);

endmodule

// File: tb/tb_id_remap_table.sv
// Directed bench for id_remap_table (4x4, 4-bit IDs) with a response scoreboard queue.
module tb_id_remap_table;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] outstanding;
    logic       full;
    logic       empty;
    int         checks = 0;
    int         errors = 0;
    logic [4:0] sb[$];

    id_remap_if #(.ID_WIDTH(4), .UID_W(4)) bus ();

    id_remap_table #(.ID_WIDTH(4), .NUM_ROWS(4), .NUM_COLS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .outstanding (outstanding),
        .full        (full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alloc_valid   = 1'b0;
        bus.alloc_orig_id = '0;
        bus.free_valid    = 1'b0;
        bus.free_uid      = '0;
    endtask

    task automatic check_rsp();
        logic [4:0] e;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_orig_id", 32'(bus.rsp_orig_id), 32'(e[3:0]));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e[4]));
        end else begin
            chk("rsp_idle_id", 32'(bus.rsp_orig_id), 32'd0);
        end
    endtask

    task automatic chk_state(input int exp_out);
        chk("outstanding", 32'(outstanding), 32'(exp_out));
        chk("full", 32'(full), 32'(exp_out == 16));
        chk("empty", 32'(empty), 32'(exp_out == 0));
    endtask

    task automatic step(input logic a_v, input logic [3:0] a_id, input logic exp_rdy,
                        input logic [3:0] exp_uid, input logic f_v, input logic [3:0] f_uid,
                        input logic [3:0] exp_id, input logic exp_err);
        bus.alloc_valid   = a_v;
        bus.alloc_orig_id = a_id;
        bus.free_valid    = f_v;
        bus.free_uid      = f_uid;
        #1;
        if (a_v) begin
            chk("alloc_ready", 32'(bus.alloc_ready), 32'(exp_rdy));
            if (exp_rdy) chk("alloc_uid", 32'(bus.alloc_uid), 32'(exp_uid));
        end
        if (f_v) sb.push_back({exp_err, exp_id});
        @(posedge clk);
        #1;
        idle();
        check_rsp();
    endtask

    task automatic alloc(input logic [3:0] id, input logic [3:0] uid);
        step(1'b1, id, 1'b1, uid, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic free_slot(input logic [3:0] uid, input logic [3:0] id);
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, uid, id, 1'b0);
    endtask

    // Requests presented while rst is high must be ignored.
    task automatic do_reset();
        rst               = 1'b1;
        bus.alloc_valid   = 1'b1;
        bus.alloc_orig_id = 4'hF;
        bus.free_valid    = 1'b1;
        bus.free_uid      = 4'h0;
        #1;
        chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_orig_id", 32'(bus.rsp_orig_id), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk_state(0);
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        idle();
        rst = 1'b0;
        #1;
        chk_state(0);
        bus.alloc_orig_id = 4'h9;
        #1;
        chk("post_rst_ready", 32'(bus.alloc_ready), 32'd1);
        chk("post_rst_uid", 32'(bus.alloc_uid), 32'd0);
        bus.alloc_orig_id = 4'h0;
        @(posedge clk);
        #1;
        check_rsp();
        chk_state(0);
    endtask

    initial begin
        idle();
        do_reset();

        // Basic allocation, free/restore and slot reuse.
        alloc(4'h3, 4'h0);
        alloc(4'h3, 4'h1);
        alloc(4'h3, 4'h2);
        chk_state(3);
        alloc(4'hA, 4'h4);
        free_slot(4'h1, 4'h3);
        chk_state(3);
        alloc(4'h3, 4'h1);
        chk_state(4);

        // Freeing a row's last slot while the same ID allocates keeps the row bound.
        do_reset();
        alloc(4'h3, 4'h0);
        step(1'b1, 4'h3, 1'b1, 4'h1, 1'b1, 4'h0, 4'h3, 1'b0);
        chk_state(1);
        alloc(4'h9, 4'h4);
        alloc(4'h3, 4'h0);
        chk_state(3);

        // A full hit row stalls instead of spilling; other IDs still proceed.
        do_reset();
        for (int c = 0; c < 4; c++) alloc(4'h5, 4'(c));
        step(1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        chk_state(4);
        alloc(4'h6, 4'h4);
        chk_state(5);

        // Fill all slots, then alloc+free in one cycle uses pre-free state.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            for (int c = 0; c < 4; c++) alloc(4'(k), 4'((k - 1) * 4 + c));
        end
        chk_state(16);
        step(1'b1, 4'h1, 1'b0, 4'h0, 1'b1, 4'h0, 4'h1, 1'b0);
        chk_state(15);
        alloc(4'h1, 4'h0);
        chk_state(16);
        for (int u = 0; u < 16; u++) free_slot(4'(u), 4'((u >> 2) + 1));
        chk_state(0);

        // Reset with work outstanding and a response pending.
        do_reset();
        for (int c = 0; c < 4; c++) alloc(4'h2, 4'(c));
        alloc(4'h8, 4'h4);
        chk_state(5);
`ifdef ID_REMAP_ERR_CHECK_EN
        step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'h7, 4'h0, 1'b1);
        chk_state(5);
        alloc(4'h8, 4'h5);
        chk_state(6);
`endif
        bus.free_valid = 1'b1;
        bus.free_uid   = 4'h0;
        @(posedge clk);
        #1;
        idle();
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
